pool_feeder: RTL and testbench

- Initiator/producer end of the pooling datapath: walks a single-channel fp16 feature map in memory window by window and streams each k x k window's elements to a pooling unit (average or max).
- Per window: loads the unit's op count, starts it, and delivers one element per accepted beat.
- Captures the unit's result, writes it to the output buffer, and clears the unit ready for the next window.

---
 rtl/pool_feeder.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_pool_feeder.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_feeder.sv
// -----------------------------------------------------------------------------
// pool_feeder
//
// Producer end of the pooling datapath. Walks a single-channel fp16 feature
// map window by window, streams each k x k window to a pooling unit, captures
// the unit's result and writes it to the output buffer.
//
// Ports
//   clk, rst            clock, synchronous active-low reset
//   start               one-cycle job start (ignored while busy)
//   cfg_*               job configuration, latched on start in IDLE
//   busy, done, err     job status; err is valid with done, held until next start
//   rd_en/rd_addr       input memory read request
//   rd_data             read data, valid RD_LAT cycles after rd_en
//   pool_ready, op_num  window start and remaining-op count to the pooling unit
//   pool_data*          element beat stream (valid/ack)
//   pool_valid/result   pooling unit result (sticky until cleared)
//   pool_clr            one-cycle clear to the pooling unit
//   wr_en/addr/data     output buffer write
// -----------------------------------------------------------------------------
module pool_feeder #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        cfg_in_w,
  input  logic [7:0]        cfg_in_h,
  input  logic [3:0]        cfg_k,
  input  logic [3:0]        cfg_stride,
  input  logic [ADDR_W-1:0] cfg_base_in,
  input  logic [ADDR_W-1:0] cfg_base_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              pool_ready,
  output logic [31:0]       op_num,
  output logic [DATA_W-1:0] pool_data,
  output logic              pool_data_valid,
  input  logic              pool_data_ack,
  input  logic              pool_valid,
  input  logic [DATA_W-1:0] pool_result,
  output logic              pool_clr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_LAUNCH,
    S_STREAM,
    S_WAIT_RES,
    S_WRITE,
    S_DONE
  } state_t;

  state_t state, state_d;

  // Latched job configuration
  logic [7:0]        in_w_q, in_h_q;
  logic [3:0]        k_q, stride_q;
  logic [ADDR_W-1:0] base_in_q, base_out_q;

  // Derived per-job constants
  logic [7:0]        kk_q;        // k*k elements per window
  logic [ADDR_W-1:0] row_step_q;  // stride*in_w: address step between window rows

  // Window walk: origin coordinates and their addresses, tracked incrementally
  logic [7:0]        ox_org, oy_org;
  logic [ADDR_W-1:0] win_addr;      // address of current window's top-left element
  logic [ADDR_W-1:0] win_row_addr;  // address of current window row's first origin
  logic [ADDR_W-1:0] out_addr;      // output address; windows are written in row-major order

  // Element walk inside a window
  logic [3:0]        kx, ky;
  logic [ADDR_W-1:0] rd_row_addr;
  logic [7:0]        rd_cnt, pop_cnt;

  // Read-latency tracking and beat FIFO
  logic [RD_LAT-1:0] rd_pipe;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  fifo_wr_ptr, fifo_rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;

  logic [DATA_W-1:0] result_q;
  logic              err_q;

  logic              cfg_bad;
  logic              x_fits, y_fits;
  logic              can_issue;
  logic              push, pop;
  logic [31:0]       inflight, occupancy;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  assign cfg_bad = (k_q == 4'd0) || (stride_q == 4'd0) ||
                   ({4'd0, k_q} > in_w_q) || ({4'd0, k_q} > in_h_q);

  // Next origin still fits when next_origin + k <= dim (10 bits avoid overflow)
  assign x_fits = ({2'b00, ox_org} + {6'd0, stride_q} + {6'd0, k_q}) <= {2'b00, in_w_q};
  assign y_fits = ({2'b00, oy_org} + {6'd0, stride_q} + {6'd0, k_q}) <= {2'b00, in_h_q};

  always_comb begin
    inflight = 32'd0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + 32'(rd_pipe[i]);
    end
    occupancy = 32'(fifo_cnt) + inflight;
  end

  // Reads already in flight reserve their FIFO slot, so the FIFO cannot overflow
  assign can_issue = occupancy < 32'(FIFO_DEPTH);

  assign pool_data_valid = (fifo_cnt != '0);
  assign pool_data       = pool_data_valid ? fifo_mem[fifo_rd_ptr] : '0;
  assign push            = rd_pipe[RD_LAT-1];
  assign pop             = pool_data_valid && pool_data_ack;

  // ---------------------------------------------------------------------------
  // Next-state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d    = state;
    rd_en      = 1'b0;
    rd_addr    = '0;
    pool_ready = 1'b0;
    op_num     = 32'd0;
    pool_clr   = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;

    unique case (state)
      S_IDLE: begin
        if (start) state_d = S_CHECK;
      end
      S_CHECK: begin
        state_d = cfg_bad ? S_DONE : S_LAUNCH;
      end
      S_LAUNCH: begin
        pool_ready = 1'b1;
        op_num     = 32'(kk_q) - 32'd1;
        state_d    = S_STREAM;
      end
      S_STREAM: begin
        op_num = 32'(kk_q) - 32'd1;
        if ((rd_cnt != kk_q) && can_issue) begin
          rd_en   = 1'b1;
          rd_addr = rd_row_addr + ADDR_W'(kx);
        end
        if ((rd_cnt == kk_q) && (pop_cnt == kk_q)) state_d = S_WAIT_RES;
      end
      S_WAIT_RES: begin
        op_num = 32'(kk_q) - 32'd1;
        if (pool_valid) state_d = S_WRITE;
      end
      S_WRITE: begin
        op_num   = 32'(kk_q) - 32'd1;
        pool_clr = 1'b1;
        wr_en    = 1'b1;
        wr_addr  = out_addr;
        wr_data  = result_q;
        state_d  = (!x_fits && !y_fits) ? S_DONE : S_LAUNCH;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);
  assign err  = err_q;

  // ---------------------------------------------------------------------------
  // Control and address registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      state        <= S_IDLE;
      in_w_q       <= '0;
      in_h_q       <= '0;
      k_q          <= '0;
      stride_q     <= '0;
      base_in_q    <= '0;
      base_out_q   <= '0;
      kk_q         <= '0;
      row_step_q   <= '0;
      ox_org       <= '0;
      oy_org       <= '0;
      win_addr     <= '0;
      win_row_addr <= '0;
      out_addr     <= '0;
      kx           <= '0;
      ky           <= '0;
      rd_row_addr  <= '0;
      rd_cnt       <= '0;
      pop_cnt      <= '0;
      result_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      state <= state_d;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            in_w_q     <= cfg_in_w;
            in_h_q     <= cfg_in_h;
            k_q        <= cfg_k;
            stride_q   <= cfg_stride;
            base_in_q  <= cfg_base_in;
            base_out_q <= cfg_base_out;
            err_q      <= 1'b0;
          end
        end
        S_CHECK: begin
          err_q        <= cfg_bad;
          kk_q         <= {4'd0, k_q} * {4'd0, k_q};
          row_step_q   <= ADDR_W'({8'd0, stride_q} * {4'd0, in_w_q});
          ox_org       <= '0;
          oy_org       <= '0;
          win_addr     <= base_in_q;
          win_row_addr <= base_in_q;
          out_addr     <= base_out_q;
        end
        S_LAUNCH: begin
          kx          <= '0;
          ky          <= '0;
          rd_row_addr <= win_addr;
          rd_cnt      <= '0;
          pop_cnt     <= '0;
        end
        S_STREAM: begin
          if (rd_en) begin
            rd_cnt <= rd_cnt + 8'd1;
            if (kx == k_q - 4'd1) begin
              kx          <= '0;
              ky          <= ky + 4'd1;
              rd_row_addr <= rd_row_addr + ADDR_W'(in_w_q);
            end else begin
              kx <= kx + 4'd1;
            end
          end
          if (pop) pop_cnt <= pop_cnt + 8'd1;
        end
        S_WAIT_RES: begin
          // Only sampled here, after every beat of the window has been popped
          if (pool_valid) result_q <= pool_result;
        end
        S_WRITE: begin
          out_addr <= out_addr + ADDR_W'(1);
          if (x_fits) begin
            ox_org   <= ox_org + {4'd0, stride_q};
            win_addr <= win_addr + ADDR_W'(stride_q);
          end else if (y_fits) begin
            ox_org       <= '0;
            oy_org       <= oy_org + {4'd0, stride_q};
            win_row_addr <= win_row_addr + row_step_q;
            win_addr     <= win_row_addr + row_step_q;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read-latency pipe and FIFO pointers. Clearing rd_pipe on reset discards any
  // read data still in flight.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_pipe     <= '0;
      fifo_wr_ptr <= '0;
      fifo_rd_ptr <= '0;
      fifo_cnt    <= '0;
    end else begin
      rd_pipe  <= (rd_pipe << 1) | RD_LAT'(rd_en);
      fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
      if (push) fifo_wr_ptr <= fifo_wr_ptr + PTR_W'(1);
      if (pop)  fifo_rd_ptr <= fifo_rd_ptr + PTR_W'(1);
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the cleared count makes stale
  // entries unreachable and pool_data is gated to zero while empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[fifo_wr_ptr] <= rd_data;
  end

endmodule

// File: tb/tb_pool_feeder.sv
module tb_pool_feeder;

  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 16;
  localparam int RD_LAT     = 2;
  localparam int FIFO_DEPTH = 4;

  logic              clk;
  logic              rst;
  logic              start;
  logic [7:0]        cfg_in_w, cfg_in_h;
  logic [3:0]        cfg_k, cfg_stride;
  logic [ADDR_W-1:0] cfg_base_in, cfg_base_out;
  logic              busy, done, err;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              pool_ready;
  logic [31:0]       op_num;
  logic [DATA_W-1:0] pool_data;
  logic              pool_data_valid;
  logic              pool_data_ack;
  logic              pool_valid;
  logic [DATA_W-1:0] pool_result;
  logic              pool_clr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  pool_feeder #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_in_w(cfg_in_w), .cfg_in_h(cfg_in_h), .cfg_k(cfg_k), .cfg_stride(cfg_stride),
    .cfg_base_in(cfg_base_in), .cfg_base_out(cfg_base_out),
    .busy(busy), .done(done), .err(err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .pool_ready(pool_ready), .op_num(op_num),
    .pool_data(pool_data), .pool_data_valid(pool_data_valid), .pool_data_ack(pool_data_ack),
    .pool_valid(pool_valid), .pool_result(pool_result), .pool_clr(pool_clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents: an injective function of the address, so a wrong address
  // shows up as a wrong beat.
  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  // Scoreboard
  logic [15:0] exp_beats[$];
  wr_t         exp_wr[$];
  int          reads_left;
  int          exp_op;
  logic        exp_err;
  int          done_cnt = 0;
  int          done_cyc;
  int          start_cyc;

  // Stimulus control for the pooling-unit model
  int          ack_mode;      // 0: always ack, 1: random ack, 2: one 10-cycle stall
  bit          stall_armed;
  int          stall_left;

  // Memory model request slots, indexed by cycle
  logic        req_v[8];
  logic [15:0] req_a[8];

  // Pooling-unit model state
  int          unit_need, unit_got, res_wait, outstanding, last_beat_cyc;
  logic [15:0] unit_max;

  initial begin
    for (int i = 0; i < 8; i++) begin
      req_v[i] = 1'b0;
      req_a[i] = '0;
    end
  end

  // Memory, pooling unit and output monitor, all evaluated mid-cycle
  always @(negedge clk) begin
    int slot;
    logic ack;
    logic [15:0] eb;
    wr_t w;

    req_v[cyc % 8] = rd_en;
    req_a[cyc % 8] = rd_addr;
    slot    = (cyc + 8 - RD_LAT) % 8;
    rd_data = req_v[slot] ? mem_f(req_a[slot]) : 16'($urandom);

    if (!rst) begin
      pool_data_ack = 1'b0;
      pool_valid    = 1'b0;
      pool_result   = '0;
      outstanding   = 0;
      res_wait      = -1;
      stall_left    = 0;
      reads_left    = 0;
      exp_beats.delete();
      exp_wr.delete();
    end else begin
      if (rd_en) begin
        check("rd_expected", 32'(reads_left > 0), 32'd1);
        check("rd_outstanding_lt_depth", 32'(outstanding < FIFO_DEPTH), 32'd1);
        if (reads_left > 0) reads_left--;
        outstanding++;
      end

      if (pool_ready) begin
        check("op_num_at_ready", op_num, 32'(exp_op));
        unit_need = int'(op_num) + 1;
        unit_got  = 0;
        unit_max  = '0;
        res_wait  = -1;
      end

      if (pool_clr) begin
        check("op_num_at_clr", op_num, 32'(exp_op));
        pool_valid = 1'b0;
      end

      if (res_wait > 0) res_wait--;
      else if (res_wait == 0) begin
        pool_valid  = 1'b1;
        pool_result = unit_max;
        res_wait    = -1;
      end
      if (!pool_valid) pool_result = 16'($urandom);

      case (ack_mode)
        0:       ack = 1'b1;
        1:       ack = ($urandom_range(0, 3) != 0);
        default: begin
          if (stall_left > 0) begin
            ack = 1'b0;
            stall_left--;
          end else ack = 1'b1;
        end
      endcase
      pool_data_ack = ack;

      if (pool_data_valid && ack) begin
        check("beat_in_queue", 32'(exp_beats.size() > 0), 32'd1);
        if (exp_beats.size() > 0) begin
          eb = exp_beats.pop_front();
          check("pool_data", 32'(pool_data), 32'(eb));
        end
        if (ack_mode == 0 && unit_got > 0)
          check("beat_gap", 32'(cyc - last_beat_cyc), 32'd1);
        last_beat_cyc = cyc;
        if (outstanding > 0) outstanding--;
        if (pool_data > unit_max) unit_max = pool_data;
        unit_got++;
        if (stall_armed && unit_got == 3) begin
          stall_left  = 10;
          stall_armed = 1'b0;
        end
        if (unit_got == unit_need) res_wait = int'($urandom_range(0, 3));
      end

      if (wr_en) begin
        check("wr_in_queue", 32'(exp_wr.size() > 0), 32'd1);
        if (exp_wr.size() > 0) begin
          w = exp_wr.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(w.addr));
          check("wr_data", 32'(wr_data), 32'(w.data));
        end
      end

      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("err_at_done", 32'(err), 32'(exp_err));
      end
    end
  end

  // Reference model: builds the expected beat and write sequences straight
  // from the window/address formulas, then pulses start.
  task automatic setup_job(input int w, input int h, input int k, input int s,
                           input logic [15:0] bin, input logic [15:0] bout, input int mode);
    int ow, oh;
    logic [15:0] a, mx;
    wr_t ew;
    exp_err = (k == 0) || (s == 0) || (k > w) || (k > h);
    exp_op  = k * k - 1;
    if (!exp_err) begin
      ow = (w - k) / s + 1;
      oh = (h - k) / s + 1;
      for (int oy = 0; oy < oh; oy++) begin
        for (int ox = 0; ox < ow; ox++) begin
          mx = '0;
          for (int ky = 0; ky < k; ky++) begin
            for (int kx = 0; kx < k; kx++) begin
              a = 16'(int'(bin) + (oy * s + ky) * w + ox * s + kx);
              exp_beats.push_back(mem_f(a));
              if (mem_f(a) > mx) mx = mem_f(a);
              reads_left++;
            end
          end
          ew.addr = 16'(int'(bout) + oy * ow + ox);
          ew.data = mx;
          exp_wr.push_back(ew);
        end
      end
    end
    ack_mode    = mode;
    stall_armed = (mode == 2);
    @(negedge clk);
    cfg_in_w     = 8'(w);
    cfg_in_h     = 8'(h);
    cfg_k        = 4'(k);
    cfg_stride   = 4'(s);
    cfg_base_in  = bin;
    cfg_base_out = bout;
    start        = 1'b1;
    start_cyc    = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_job(input string tag, input int d0, input bit poke);
    for (int i = 0; i < 5000; i++) begin
      if (done_cnt != d0) break;
      @(negedge clk);
      if (poke && i == 3) begin
        start        = 1'b1;
        cfg_k        = 4'd0;
        cfg_base_out = 16'hFFFF;
      end else if (poke && i == 4) begin
        start = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
    check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_err_held"}, 32'(err), 32'(exp_err));
    check({tag, "_beats_left"}, 32'(exp_beats.size()), 32'd0);
    check({tag, "_writes_left"}, 32'(exp_wr.size()), 32'd0);
    check({tag, "_reads_left"}, 32'(reads_left), 32'd0);
    if (exp_err) check({tag, "_err_latency_le3"}, 32'(done_cyc - start_cyc <= 3), 32'd1);
  endtask

  task automatic run_job(input string tag, input int w, input int h, input int k, input int s,
                         input logic [15:0] bin, input logic [15:0] bout, input int mode,
                         input bit poke);
    int d0;
    d0 = done_cnt;
    setup_job(w, h, k, s, bin, bout, mode);
    finish_job(tag, d0, poke);
  endtask

  task automatic check_outputs_idle(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    check({tag, "_pool_ready"}, 32'(pool_ready), 32'd0);
    check({tag, "_op_num"}, op_num, 32'd0);
    check({tag, "_pool_data"}, 32'(pool_data), 32'd0);
    check({tag, "_pool_data_valid"}, 32'(pool_data_valid), 32'd0);
    check({tag, "_pool_clr"}, 32'(pool_clr), 32'd0);
    check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
  endtask

  initial begin
    int d0, w, h, k, s;
    rst          = 1'b0;
    start        = 1'b0;
    cfg_in_w     = '0;
    cfg_in_h     = '0;
    cfg_k        = '0;
    cfg_stride   = '0;
    cfg_base_in  = '0;
    cfg_base_out = '0;
    ack_mode     = 0;
    stall_armed  = 1'b0;
    exp_op       = 0;
    exp_err      = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_idle("reset");
    rst = 1'b1;
    @(negedge clk);

    run_job("j4x4",   4, 4, 2, 2, 16'h0000, 16'h0000, 0, 1'b1);
    run_job("j3x3",   3, 3, 3, 1, 16'h0000, 16'h0040, 0, 1'b0);
    run_job("j5x5",   5, 5, 3, 2, 16'h0100, 16'h0200, 1, 1'b0);
    run_job("jstall", 3, 3, 3, 1, 16'h0020, 16'h0300, 2, 1'b0);
    run_job("jk0",    5, 5, 0, 1, 16'h0000, 16'h0000, 0, 1'b0);
    run_job("jk6",    5, 5, 6, 1, 16'h0000, 16'h0000, 0, 1'b0);
    run_job("jwrap",  4, 3, 2, 1, 16'hFFF8, 16'hFFFE, 1, 1'b0);

    for (int j = 0; j < 8; j++) begin
      w = int'($urandom_range(1, 9));
      h = int'($urandom_range(1, 9));
      k = int'($urandom_range(1, 4));
      s = int'($urandom_range(1, 3));
      run_job("jrand", w, h, k, s, 16'($urandom), 16'($urandom), int'($urandom_range(0, 1)), 1'b0);
    end

    // Reset in the middle of streaming abandons the job without a done pulse
    d0 = done_cnt;
    setup_job(6, 6, 3, 1, 16'h0000, 16'h0000, 1);
    repeat (6) @(negedge clk);
    check("midrst_busy_before", 32'(busy), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check_outputs_idle("midrst");
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    check("midrst_still_idle", 32'(busy), 32'd0);

    run_job("jafter", 4, 4, 2, 2, 16'h0010, 16'h0050, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
